// File: rtl/plab4_net_router_input_unit.sv
`default_nettype none
// ============================================================================
// Module   : plab4_net_router_input_unit
// Purpose  : Buffered ring-router input port. A circular FIFO holds incoming
//            messages, and a shortest-path one-hot request is raised for the head.
// Revision : 1.0 - initial release
// ============================================================================
module plab4_net_router_input_unit #(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 8,
    parameter int p_msg_nbits   = 32,
    parameter int p_dest_lsb    = 0,
    parameter int p_num_entries = 4,
    parameter bit p_tie_east    = 1'b1,
    localparam int c_dest_nbits = $clog2(p_num_routers),
    localparam int c_cnt_nbits  = $clog2(p_num_entries) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_msg_nbits-1:0] in_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [2:0]             reqs,
    input  logic [2:0]             grants,
    output logic [c_cnt_nbits-1:0] count,
    output logic                   bad_dest
);

    localparam int c_ptr_nbits = $clog2(p_num_entries);
    // Two extra bits so that dest + N and 2*fwd never overflow.
    localparam int c_ext_nbits = c_dest_nbits + 2;

    localparam logic [c_ext_nbits-1:0] c_id    = c_ext_nbits'(p_router_id);
    localparam logic [c_ext_nbits-1:0] c_n     = c_ext_nbits'(p_num_routers);
    localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_num_entries);

    localparam logic [2:0] c_req_east = 3'b100;
    localparam logic [2:0] c_req_term = 3'b010;
    localparam logic [2:0] c_req_west = 3'b001;

    logic [p_msg_nbits-1:0] r_mem [p_num_entries];
    logic [c_ptr_nbits-1:0] r_head;
    logic [c_ptr_nbits-1:0] r_tail;
    logic [c_cnt_nbits-1:0] r_count;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_enq;
    logic                    w_deq;
    logic [c_dest_nbits-1:0] w_dest;
    logic [c_ext_nbits-1:0]  w_dest_x;
    logic [c_ext_nbits-1:0]  w_fwd;
    logic [c_ext_nbits-1:0]  w_fwd2;
    logic                    w_bad;
    logic [2:0]              w_route;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    // A full FIFO refuses input even when the head leaves this cycle.
    assign in_rdy  = !w_full && reset;
    assign w_enq   = in_val && in_rdy;
    assign w_deq   = |(reqs & grants);

    assign out_msg = r_mem[r_head];
    assign count   = r_count;

    assign w_dest   = out_msg[p_dest_lsb +: c_dest_nbits];
    assign w_dest_x = {2'b00, w_dest};
    assign w_fwd    = (w_dest_x >= c_id) ? (w_dest_x - c_id) : (w_dest_x + c_n - c_id);
    assign w_fwd2   = w_fwd << 1;
    assign w_bad    = (w_dest_x >= c_n);

    always_comb begin
        w_route = 3'b000;
        if (w_empty) begin
            w_route = 3'b000;
        end else if (w_bad || (w_dest_x == c_id)) begin
            w_route = c_req_term;
        end else if (w_fwd2 < c_n) begin
            w_route = c_req_east;
        end else if (w_fwd2 > c_n) begin
            w_route = c_req_west;
        end else begin
            w_route = p_tie_east ? c_req_east : c_req_west;
        end
    end

    assign reqs     = w_route;
    assign bad_dest = !w_empty && w_bad;

    // Storage is deliberately left unreset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= in_msg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_ptr_nbits'(1);
            end
            if (w_deq) begin
                r_head <= r_head + c_ptr_nbits'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_nbits'(1);
                2'b01:   r_count <= r_count - c_cnt_nbits'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plab4_net_router_input_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_plab4_net_router_input_unit
// Purpose  : Directed self-checking bench for the buffered router input unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plab4_net_router_input_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] msg0, msg1;
    logic        val0, val1;
    logic [2:0]  gnt0, gnt1;

    logic        rdy0, rdy1, rdy2;
    logic [31:0] out0, out1, out2;
    logic [2:0]  reqs0, reqs1, reqs2;
    logic [2:0]  cnt0, cnt1, cnt2;
    logic        bad0, bad1, bad2;

    int checks = 0;
    int errors = 0;

    // Expected request for router 2 of 8, tie east, indexed by destination.
    logic [2:0] route_tbl [8];

    plab4_net_router_input_unit #(
        .p_router_id(2), .p_num_routers(8), .p_msg_nbits(32),
        .p_dest_lsb(0), .p_num_entries(4), .p_tie_east(1'b1)
    ) u0 (
        .clk(clk), .reset(reset), .in_msg(msg0), .in_val(val0), .in_rdy(rdy0),
        .out_msg(out0), .reqs(reqs0), .grants(gnt0), .count(cnt0), .bad_dest(bad0)
    );

    plab4_net_router_input_unit #(
        .p_router_id(2), .p_num_routers(8), .p_msg_nbits(32),
        .p_dest_lsb(0), .p_num_entries(4), .p_tie_east(1'b0)
    ) u1 (
        .clk(clk), .reset(reset), .in_msg(msg1), .in_val(val1), .in_rdy(rdy1),
        .out_msg(out1), .reqs(reqs1), .grants(gnt1), .count(cnt1), .bad_dest(bad1)
    );

    plab4_net_router_input_unit #(
        .p_router_id(4), .p_num_routers(5), .p_msg_nbits(32),
        .p_dest_lsb(0), .p_num_entries(4), .p_tie_east(1'b1)
    ) u2 (
        .clk(clk), .reset(reset), .in_msg(msg1), .in_val(val1), .in_rdy(rdy2),
        .out_msg(out2), .reqs(reqs2), .grants(gnt1), .count(cnt2), .bad_dest(bad2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (cnt0 !== 3'd0)   begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
        checks++; if (reqs0 !== 3'b000) begin errors++; $display("FAIL reset_reqs: got %b expected 000", reqs0); end
        checks++; if (rdy0 !== 1'b0)   begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy0); end
        checks++; if (bad0 !== 1'b0)   begin errors++; $display("FAIL reset_bad: got %b expected 0", bad0); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b1)   begin errors++; $display("FAIL post_reset_rdy: got %b expected 1", rdy0); end
        checks++; if (cnt0 !== 3'd0)   begin errors++; $display("FAIL post_reset_count: got %0d expected 0", cnt0); end
    endtask

    task automatic test_routing();
        logic [2:0]  dst   [5] = '{3'd2, 3'd5, 3'd6, 3'd7, 3'd0};
        logic [2:0]  exp_r [5] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        logic [31:0] m;
        for (int i = 0; i < 5; i++) begin
            m    = {16'hC0DE, 8'(i), 5'd0, dst[i]};
            msg0 = m;
            val0 = 1'b1;
            checks++; if (reqs0 !== 3'b000) begin errors++; $display("FAIL route_pre_reqs[%0d]: got %b expected 000", i, reqs0); end
            tick();
            val0 = 1'b0;
            checks++; if (reqs0 !== exp_r[i]) begin errors++; $display("FAIL route_reqs[%0d]: got %b expected %b", i, reqs0, exp_r[i]); end
            checks++; if (out0 !== m)         begin errors++; $display("FAIL route_msg[%0d]: got %h expected %h", i, out0, m); end
            checks++; if (cnt0 !== 3'd1)      begin errors++; $display("FAIL route_count[%0d]: got %0d expected 1", i, cnt0); end
            gnt0 = exp_r[i];
            tick();
            gnt0 = 3'b000;
            checks++; if (cnt0 !== 3'd0)      begin errors++; $display("FAIL route_drain[%0d]: got %0d expected 0", i, cnt0); end
            checks++; if (reqs0 !== 3'b000)   begin errors++; $display("FAIL route_empty_reqs[%0d]: got %b expected 000", i, reqs0); end
        end
    endtask

    // u1: N=8 id=2 tie west; u2: N=5 id=4. Both see the same input stream.
    task automatic test_route_alt();
        logic [2:0]  dst [5] = '{3'd1, 3'd2, 3'd6, 3'd7, 3'd4};
        logic [2:0]  e1  [5] = '{3'b001, 3'b010, 3'b001, 3'b001, 3'b100};
        logic [2:0]  e2  [5] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b010};
        logic        b2  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] m;
        checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL alt_rdy: got %b%b expected 11", rdy1, rdy2); end
        for (int i = 0; i < 5; i++) begin
            m    = {16'hA17E, 8'(i), 5'd0, dst[i]};
            msg1 = m;
            val1 = 1'b1;
            tick();
            val1 = 1'b0;
            checks++; if (reqs1 !== e1[i]) begin errors++; $display("FAIL alt_west_reqs[%0d]: got %b expected %b", i, reqs1, e1[i]); end
            checks++; if (bad1 !== 1'b0)   begin errors++; $display("FAIL alt_west_bad[%0d]: got %b expected 0", i, bad1); end
            checks++; if (out1 !== m)      begin errors++; $display("FAIL alt_west_msg[%0d]: got %h expected %h", i, out1, m); end
            checks++; if (reqs2 !== e2[i]) begin errors++; $display("FAIL alt_n5_reqs[%0d]: got %b expected %b", i, reqs2, e2[i]); end
            checks++; if (bad2 !== b2[i])  begin errors++; $display("FAIL alt_n5_bad[%0d]: got %b expected %b", i, bad2, b2[i]); end
            checks++; if (out2 !== m)      begin errors++; $display("FAIL alt_n5_msg[%0d]: got %h expected %h", i, out2, m); end
            gnt1 = 3'b111;
            tick();
            gnt1 = 3'b000;
            checks++; if (cnt1 !== 3'd0 || cnt2 !== 3'd0) begin errors++; $display("FAIL alt_drain[%0d]: got %0d/%0d expected 0/0", i, cnt1, cnt2); end
        end
    endtask

    task automatic test_full();
        logic [31:0] m;
        gnt0 = 3'b000;
        val0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            msg0 = {16'hF00D, 8'(i), 8'h03};
            checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL full_fill_rdy[%0d]: got %b expected 1", i, rdy0); end
            tick();
        end
        checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", cnt0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b expected 0", rdy0); end
        msg0 = 32'hDEAD_FF03;
        tick();
        checks++; if (cnt0 !== 3'd4) begin errors++; $display("FAIL full_no_write: got %0d expected 4", cnt0); end
        m = {16'hF00D, 8'd0, 8'h03};
        checks++; if (out0 !== m)    begin errors++; $display("FAIL full_head: got %h expected %h", out0, m); end
        // Dequeue while still offering: the offered message must be refused.
        gnt0 = 3'b100;
        tick();
        val0 = 1'b0;
        checks++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL full_first_deq: got %0d expected 3", cnt0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %b expected 1", rdy0); end
        for (int i = 1; i < 4; i++) begin
            m = {16'hF00D, 8'(i), 8'h03};
            checks++; if (out0 !== m) begin errors++; $display("FAIL full_order[%0d]: got %h expected %h", i, out0, m); end
            tick();
        end
        gnt0 = 3'b000;
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", cnt0); end
    endtask

    task automatic test_hold();
        gnt0 = 3'b111;
        tick();
        gnt0 = 3'b000;
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL hold_empty_grant: got %0d expected 0", cnt0); end
        msg0 = 32'h0000_AB03;
        val0 = 1'b1;
        tick();
        val0 = 1'b0;
        gnt0 = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (reqs0 !== 3'b100) begin errors++; $display("FAIL hold_reqs[%0d]: got %b expected 100", i, reqs0); end
            checks++; if (cnt0 !== 3'd1)    begin errors++; $display("FAIL hold_count[%0d]: got %0d expected 1", i, cnt0); end
        end
        gnt0 = 3'b100;
        tick();
        gnt0 = 3'b000;
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL hold_release: got %0d expected 0", cnt0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        logic [2:0]  pd;
        gnt0 = 3'b000;
        msg0 = {16'hB2B0, 8'd0, 5'd0, 3'd0};
        val0 = 1'b1;
        tick();
        prev = msg0;
        for (int i = 1; i < 20; i++) begin
            pd   = prev[2:0];
            gnt0 = route_tbl[pd];
            msg0 = {16'hB2B0, 8'(i), 5'd0, 3'(i)};
            checks++; if (out0 !== prev)          begin errors++; $display("FAIL b2b_msg[%0d]: got %h expected %h", i, out0, prev); end
            checks++; if (reqs0 !== route_tbl[pd]) begin errors++; $display("FAIL b2b_reqs[%0d]: got %b expected %b", i, reqs0, route_tbl[pd]); end
            checks++; if (cnt0 !== 3'd1)          begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, cnt0); end
            tick();
            prev = msg0;
        end
        val0 = 1'b0;
        pd   = prev[2:0];
        gnt0 = route_tbl[pd];
        checks++; if (out0 !== prev) begin errors++; $display("FAIL b2b_last_msg: got %h expected %h", out0, prev); end
        tick();
        gnt0 = 3'b000;
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", cnt0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] m;
        gnt0 = 3'b000;
        val0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            msg0 = {16'h5E70, 8'(i), 8'h03};
            tick();
        end
        val0 = 1'b0;
        checks++; if (cnt0 !== 3'd3) begin errors++; $display("FAIL mid_fill: got %0d expected 3", cnt0); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (cnt0 !== 3'd0)    begin errors++; $display("FAIL mid_async_count: got %0d expected 0", cnt0); end
        checks++; if (reqs0 !== 3'b000) begin errors++; $display("FAIL mid_async_reqs: got %b expected 000", reqs0); end
        checks++; if (rdy0 !== 1'b0)    begin errors++; $display("FAIL mid_async_rdy: got %b expected 0", rdy0); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL mid_release_rdy: got %b expected 1", rdy0); end
        m    = 32'h1234_5605;
        msg0 = m;
        val0 = 1'b1;
        tick();
        val0 = 1'b0;
        checks++; if (out0 !== m)       begin errors++; $display("FAIL mid_new_msg: got %h expected %h", out0, m); end
        checks++; if (reqs0 !== 3'b100) begin errors++; $display("FAIL mid_new_reqs: got %b expected 100", reqs0); end
        checks++; if (cnt0 !== 3'd1)    begin errors++; $display("FAIL mid_new_count: got %0d expected 1", cnt0); end
        gnt0 = 3'b100;
        tick();
        gnt0 = 3'b000;
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL mid_new_drain: got %0d expected 0", cnt0); end
    endtask

    initial begin
        reset = 1'b0;
        val0  = 1'b0;
        val1  = 1'b0;
        msg0  = '0;
        msg1  = '0;
        gnt0  = 3'b000;
        gnt1  = 3'b000;
        route_tbl[0] = 3'b001; route_tbl[1] = 3'b001;
        route_tbl[2] = 3'b010; route_tbl[3] = 3'b100;
        route_tbl[4] = 3'b100; route_tbl[5] = 3'b100;
        route_tbl[6] = 3'b100; route_tbl[7] = 3'b001;

        test_reset();
        test_routing();
        test_route_alt();
        test_full();
        test_hold();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
